// File: rtl/xorshift_prng_arbiter_pkg.sv
// Shared types and constants for the xorshift256+ front-end arbiter.
package xorshift_pkg;

    // Seed is four 64-bit state words {s3,s2,s1,s0}; the core emits one 64-bit word per step.
    localparam int SEED_W = 256;
    localparam int WORD_W = 64;

    // Width of the warm-up step counter (WARMUP may be up to 65535).
    localparam int WARM_W = 16;

    // Controller states: no usable seed, core load, discarded warm-up steps, serving requesters.
    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WARMUP   = 2'd2,
        ST_RUN      = 2'd3
    } state_e;

    // Wrapping increment of a round-robin index in the range 0..n-1.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xorshift_prng_arbiter_core.sv
// xorshift256+ generator core: 256 bits of state, one step per enabled clock.
// rst loads the seed synchronously; out is the sum s0+s3 of the current state,
// so the word for step n is visible before the edge that advances to step n+1.
module xorshift256_plus
    import xorshift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SEED_W-1:0] seed,
    input  logic              en,
    output logic [WORD_W-1:0] out
);

    logic [WORD_W-1:0] s0_q, s1_q, s2_q, s3_q;
    logic [WORD_W-1:0] s0_d, s1_d, s2_d, s3_d;
    logic [WORD_W-1:0] t_shift;
    logic [WORD_W-1:0] s2_mix;
    logic [WORD_W-1:0] s3_mix;

    // Next-state computation of the xorshift256+ step, applied only when enabled.
    always_comb begin
        t_shift = s1_q << 17;
        s2_mix  = s2_q ^ s0_q;
        s3_mix  = s3_q ^ s1_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        if (en) begin
            s1_d = s1_q ^ s2_mix;
            s0_d = s0_q ^ s3_mix;
            s2_d = s2_mix ^ t_shift;
            s3_d = {s3_mix[WORD_W-46:0], s3_mix[WORD_W-1:WORD_W-45]};
        end
    end

    // State register: seed load has priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q <= seed[0*WORD_W +: WORD_W];
            s1_q <= seed[1*WORD_W +: WORD_W];
            s2_q <= seed[2*WORD_W +: WORD_W];
            s3_q <= seed[3*WORD_W +: WORD_W];
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out = s0_q + s3_q;

endmodule

// File: rtl/xorshift_prng_arbiter.sv
// Front-end controller that seeds one xorshift256+ core, discards WARMUP steps
// after every seed load, then hands out one 64-bit word per cycle round-robin.
// Delivery handshake: requesters hold req high as a level; a grant in cycle t
// is answered by a one-cycle rnd_valid[g] strobe in cycle t+1 with rnd_data
// qualified by it. There is no back-pressure and nothing is queued.
module xorshift_prng_arbiter
    import xorshift_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WARMUP  = 16,
    parameter int CNT_W   = 32
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_valid,
    input  logic [SEED_W-1:0]  seed,
    output logic               seed_err,
    output logic               ready,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] rnd_valid,
    output logic [WORD_W-1:0]  rnd_data,
    output logic [CNT_W-1:0]   gen_count,
    output state_e             dbg_state
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [WARM_W-1:0] WARM_LAST = (WARMUP == 0) ? '0 : WARM_W'(WARMUP - 1);

    state_e              state_q,     state_d;
    logic                seed_err_q,  seed_err_d;
    logic                ready_q,     ready_d;
    logic [NUM_REQ-1:0]  rnd_valid_q, rnd_valid_d;
    logic [WORD_W-1:0]   rnd_data_q,  rnd_data_d;
    logic [CNT_W-1:0]    gen_count_q, gen_count_d;
    logic [PTR_W-1:0]    ptr_q,       ptr_d;
    logic [WARM_W-1:0]   warm_cnt_q,  warm_cnt_d;
    logic [SEED_W-1:0]   seed_lat_q,  seed_lat_d;
    logic                core_rst_q,  core_rst_d;

    logic                core_en;
    logic [WORD_W-1:0]   core_out;
    logic                zero_seed;
    logic                good_seed;
    logic [PTR_W:0]      pick;
    logic                pick_found;
    logic [PTR_W-1:0]    pick_idx;

    // Round-robin pick: first asserted request at index >= p, wrapping; returns {found, index}.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [PTR_W-1:0]   p);
        logic             found;
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] jj;
        int               j;
        found = 1'b0;
        idx   = p;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(p) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = PTR_W'(j);
            if (!found && r[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
        return {found, idx};
    endfunction

    xorshift256_plus u_core (
        .clk  (clk),
        .rst  (core_rst_q),
        .seed (seed_lat_q),
        .en   (core_en),
        .out  (core_out)
    );

    assign zero_seed  = seed_valid && (seed == '0);
    assign good_seed  = seed_valid && (seed != '0);
    assign pick       = rr_pick(req, ptr_q);
    assign pick_found = pick[PTR_W];
    assign pick_idx   = pick[PTR_W-1:0];

    // Next-state and output decode for the seed / warm-up / run sequence.
    always_comb begin
        state_d     = state_q;
        seed_err_d  = zero_seed;
        rnd_valid_d = '0;
        rnd_data_d  = rnd_data_q;
        gen_count_d = gen_count_q;
        ptr_d       = ptr_q;
        warm_cnt_d  = warm_cnt_q;
        seed_lat_d  = seed_lat_q;
        core_rst_d  = 1'b0;
        core_en     = 1'b0;

        case (state_q)
            ST_UNSEEDED: begin
                if (good_seed) begin
                    state_d    = ST_LOAD;
                    seed_lat_d = seed;
                    core_rst_d = 1'b1;
                end
            end
            ST_LOAD: begin
                // Core is loading this cycle; seed_valid is ignored here.
                gen_count_d = '0;
                warm_cnt_d  = '0;
                state_d     = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            end
            ST_WARMUP: begin
                core_en = 1'b1;
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end
            ST_RUN: begin
                if (good_seed) begin
                    // Reseed wins over any request in the same cycle.
                    state_d    = ST_LOAD;
                    seed_lat_d = seed;
                    core_rst_d = 1'b1;
                end else if (pick_found) begin
                    core_en     = 1'b1;
                    rnd_valid_d = NUM_REQ'(1) << pick_idx;
                    rnd_data_d  = core_out;
                    gen_count_d = gen_count_q + CNT_W'(1);
                    ptr_d       = PTR_W'(rr_next(int'(pick_idx), NUM_REQ));
                end
            end
            default: begin
                state_d = ST_UNSEEDED;
            end
        endcase

        ready_d = (state_d == ST_RUN);
    end

    // Controller state and registered outputs; rst does not touch the core itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNSEEDED;
            seed_err_q  <= 1'b0;
            ready_q     <= 1'b0;
            rnd_valid_q <= '0;
            rnd_data_q  <= '0;
            gen_count_q <= '0;
            ptr_q       <= '0;
            warm_cnt_q  <= '0;
            seed_lat_q  <= '0;
            core_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_err_q  <= seed_err_d;
            ready_q     <= ready_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            gen_count_q <= gen_count_d;
            ptr_q       <= ptr_d;
            warm_cnt_q  <= warm_cnt_d;
            seed_lat_q  <= seed_lat_d;
            core_rst_q  <= core_rst_d;
        end
    end

    assign seed_err  = seed_err_q;
    assign ready     = ready_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign gen_count = gen_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_xorshift_prng_arbiter.sv
// Bench for xorshift_prng_arbiter: driver tasks push expected deliveries from a
// sequence-level model of the generator and arbiter; a monitor pops and compares.
module tb_xorshift_prng_arbiter;
    import xorshift_pkg::*;

    localparam int N  = 4;
    localparam int WU = 16;
    localparam int CW = 32;
    localparam int EW = N + CW + 64;

    localparam logic [255:0] SEED_A = {64'h9E3779B97F4A7C15, 64'hD2B74407B1CE6E93,
                                       64'h94D049BB133111EB, 64'h12345678ABCDEF00};

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          seed_valid = 1'b0;
    logic [255:0]  seed = '0;
    logic [N-1:0]  req = '0;
    logic          seed_err;
    logic          ready;
    logic [N-1:0]  rnd_valid;
    logic [63:0]   rnd_data;
    logic [CW-1:0] gen_count;
    state_e        dbg_state;

    always #5 clk = ~clk;

    xorshift_prng_arbiter #(.NUM_REQ(N), .WARMUP(WU), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_err   (seed_err),
        .ready      (ready),
        .req        (req),
        .rnd_valid  (rnd_valid),
        .rnd_data   (rnd_data),
        .gen_count  (gen_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [EW-1:0] exp_q[$];
    logic [63:0]   last_data = '0;

    // Reference model: generator state words, arbiter pointer, delivered count.
    logic [63:0]   ms[4];
    int            m_ptr = 0;
    logic [CW-1:0] m_gen = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] x, input int k);
        return (x << k) | (x >> (64 - k));
    endfunction

    task automatic model_step();
        logic [63:0] t;
        t     = ms[1] << 17;
        ms[2] = ms[2] ^ ms[0];
        ms[3] = ms[3] ^ ms[1];
        ms[1] = ms[1] ^ ms[2];
        ms[0] = ms[0] ^ ms[3];
        ms[2] = ms[2] ^ t;
        ms[3] = rotl(ms[3], 45);
    endtask

    // Model after a seed load: state = seed advanced WU steps, so the next word is output WU+1.
    task automatic model_seed(input logic [255:0] s);
        for (int i = 0; i < 4; i++) ms[i] = s[64*i +: 64];
        for (int i = 0; i < WU; i++) model_step();
        m_gen = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One RUN cycle with request vector r; expected delivery pushed when someone wins.
    task automatic run_cycle(input logic [N-1:0] r);
        logic [N-1:0] oh;
        int           win;
        req = r;
        win = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        if (win >= 0) begin
            oh      = '0;
            oh[win] = 1'b1;
            m_gen   = m_gen + 1;
            exp_q.push_back({oh, m_gen, ms[0] + ms[3]});
            model_step();
            m_ptr = (win + 1) % N;
        end
        tick();
    endtask

    // Present a nonzero seed for one cycle (req held at hold_req) and time the ready rise.
    task automatic seed_and_wait(input logic [255:0] s, input logic [N-1:0] hold_req);
        int n;
        seed_valid = 1'b1;
        seed       = s;
        req        = hold_req;
        tick();
        seed_valid = 1'b0;
        seed       = '0;
        check("ready_low_after_seed", ready, 0);
        n = 1;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        req = '0;
        check("seed_to_ready_cycles", n, WU + 2);
        check("gen_count_after_load", gen_count, 0);
        model_seed(s);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_data = '0;
            end else if (rnd_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rnd_valid", rnd_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_valid", rnd_valid, e[EW-1 -: N]);
                    check("rnd_data", rnd_data, e[63:0]);
                    check("gen_count", gen_count, e[64 +: CW]);
                    last_data = e[63:0];
                end
            end else begin
                check("rnd_data_hold", rnd_data, last_data);
            end
        end
    end

    // Watchdog: the sequence below is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset with all requests high.
        rst = 1'b1;
        req = '1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_ready", ready, 0);
            check("reset_rnd_valid", rnd_valid, 0);
            check("reset_rnd_data", rnd_data, 0);
            check("reset_gen_count", gen_count, 0);
            check("reset_seed_err", seed_err, 0);
            check("reset_state", dbg_state, ST_UNSEEDED);
        end
        req = '0;

        // Zero seed is rejected with a single-cycle error pulse.
        seed_valid = 1'b1;
        seed       = '0;
        tick();
        seed_valid = 1'b0;
        check("zero_seed_err_pulse", seed_err, 1);
        tick();
        check("zero_seed_err_clear", seed_err, 0);
        check("zero_seed_ready", ready, 0);
        check("zero_seed_state", dbg_state, ST_UNSEEDED);

        // Seed load with requests held during warm-up (they must be ignored).
        seed_and_wait(SEED_A, '1);

        // Contention: rotation 0001,0010,0100,1000,0001, then a single requester.
        for (int i = 0; i < 5; i++) run_cycle(4'b1111);
        for (int i = 0; i < 4; i++) run_cycle(4'b0100);
        run_cycle(4'b0000);

        // Random request patterns.
        for (int i = 0; i < 40; i++) run_cycle(N'($urandom_range(0, (1 << N) - 1)));

        // Reseed mid-RUN with requests held in the seed cycle.
        run_cycle(4'b1111);
        seed_and_wait(SEED_A, 4'b1111);
        for (int i = 0; i < 6; i++) run_cycle(4'b1011);

        // Reset during warm-up, then a full reseed.
        seed_valid = 1'b1;
        seed       = SEED_A ^ 256'h1;
        tick();
        seed_valid = 1'b0;
        seed       = '0;
        repeat (6) tick();
        check("queue_empty_before_rst", exp_q.size(), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        check("rst_warmup_ready", ready, 0);
        check("rst_warmup_gen_count", gen_count, 0);
        check("rst_warmup_state", dbg_state, ST_UNSEEDED);
        req = '1;
        repeat (5) tick();
        req = '0;
        seed_and_wait(SEED_A, '0);
        for (int i = 0; i < 8; i++) run_cycle(N'($urandom_range(1, (1 << N) - 1)));
        run_cycle(4'b0000);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
